uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Buffered, runtime-configurable UART transmitter; next generation of the project's fixed-format TX.
//   Accepts words on a valid/ready stream into an internal FIFO.
//   Serialises each word as start + DATA_BITS (LSB first) + optional parity + 1 or 2 stop bits.
//   Bit period, parity mode and stop-bit count are runtime inputs, so one instance serves several links.
// PARAMETERS
//   DATA_BITS   8    data bits per frame, 5..9
//   FIFO_DEPTH  16   FIFO entries, power of two, >=2
//   DIV_W       16   width of cfg_div
// PORTS
//   clk          in   1                          clock
//   rstn         in   1                          asynchronous reset, active-low
//   s_valid      in   1                          word offered
//   s_data       in   DATA_BITS                  word to send
//   s_ready      out  1                          FIFO can accept (not full)
//   cfg_div      in   DIV_W                      clocks per bit; 0 treated as 1
//   cfg_parity   in   2                          00 none, 01 even, 10 odd, 11 mark (always 1)
//   cfg_stop2    in   1                          1 = two stop bits
//   tx           out  1                          serial line, idle high
//   busy         out  1                          frame in progress or FIFO non-empty
//   level        out  $clog2(FIFO_DEPTH)+1       FIFO occupancy
//   frame_done   out  1                          1-clk pulse at end of each frame's last stop bit
// BEHAVIOUR
//   Reset (async, rstn=0): tx=1, s_ready=1, busy=0, level=0, frame_done=0; FSM=IDLE; FIFO flushed.
//   Reset mid-frame: tx returns high immediately; partial frame and queued words are discarded.
//   Push: s_valid&&s_ready at an edge writes s_data. s_ready = (level!=FIFO_DEPTH), combinational from level.
//   Full: s_ready=0; s_valid is ignored and data is not lost upstream.
//   Level: push-only +1, pop-only -1, push+pop same edge unchanged. Pointers wrap modulo FIFO_DEPTH.
//   FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE:
//     - If level!=0, pop the head word at the next edge.
//     - Latch cfg_div, cfg_parity and cfg_stop2 into shadow registers; go to START.
//     - tx goes 0 at that same edge, so first-word latency is 1 clk after the push edge when idle.
//   Timing: each state holds for max(cfg_div,1) clocks, counted from the shadow copy.
//     cfg changes mid-frame affect only the next frame.
//   START -> DATA. DATA shifts out DATA_BITS bits LSB first.
//     Then PARITY if parity!=00, else STOP.
//   Parity bit: even = ^data; odd = ~^data; mark = 1.
//   STOP: tx=1 for 1 or 2 bit periods.
//     On the final clock: frame_done=1 for one clk.
//     If level!=0: pop and go to START, with tx low on the very next clk (no idle gap).
//     Else go to IDLE.
//   Frame length (clks) = div*(1+DATA_BITS+(parity?1:0)+(stop2?2:1)).
//   tx is registered; no glitches. busy = (state!=IDLE) || (level!=0).
//   Bit counter width = $clog2(DATA_BITS)+1; divider counter width = DIV_W.
//     Neither counter wraps within a frame.
// TESTING
//   1. 0x55, div=4, even parity, 1 stop
//      -> tx: 0, 1,0,1,0,1,0,1,0, 0, 1, each 4 clk; 44 clk total; frame_done once.
//   2. Same word, odd parity, stop2=1 -> parity bit 1, stop high 8 clk, 48 clk total.
//   3. Parity none, div=0 -> treated as 1; 10-clk frame; tx low 1 clk after push.
//   4. Push 17 words back-to-back while sending
//      -> s_ready low when level=16; no word dropped or duplicated; frames contiguous, no idle gap.
//   5. Change cfg_div 4->8 mid-frame -> current frame keeps 4 clk/bit, next frame uses 8.
//   6. Assert rstn low during DATA with 3 words queued
//      -> tx=1, level=0, s_ready=1 immediately; no frame_done; after release, IDLE stays idle.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter with runtime bit period, parity and stop-bit selection.
// Words enter a FIFO on a valid/ready stream and are sent back to back with no idle gap.
module uart_tx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        s_valid,
    input  logic [DATA_BITS-1:0]        s_data,
    output logic                        s_ready,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        frame_done
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(DATA_BITS) + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 push;
    logic                 pop_c;
    logic [DATA_BITS-1:0] head;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d, div_step;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_d;
    logic                 frame_done_d;
    logic                 last_tick;
    logic                 load_frame;

    assign s_ready = (level != LVL_W'(FIFO_DEPTH));
    assign push    = s_valid && s_ready;
    assign head    = mem[rd_ptr];
    assign busy    = (state_q != IDLE) || (level != '0);

    // FIFO storage needs no reset: contents are only read below the level count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop_c)      level <= level + LVL_W'(1);
            else if (!push && pop_c) level <= level - LVL_W'(1);
        end
    end

    // Frame state and shadow configuration register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            div_q      <= DIV_W'(1);
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            tx         <= tx_d;
            frame_done <= frame_done_d;
        end
    end

    assign last_tick = (div_cnt_q == div_q - DIV_W'(1));
    assign div_step  = last_tick ? '0 : div_cnt_q + DIV_W'(1);

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        stop2_d      = stop2_q;
        pop_c        = 1'b0;
        load_frame   = 1'b0;
        tx_d         = 1'b1;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (level != '0) load_frame = 1'b1;
            end
            START: begin
                div_cnt_d = div_step;
                if (last_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                div_cnt_d = div_step;
                if (last_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                div_cnt_d = div_step;
                if (last_tick) begin
                    bit_cnt_d = '0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                div_cnt_d = div_step;
                if (last_tick) begin
                    if (stop2_q && (bit_cnt_q == '0)) begin
                        bit_cnt_d = BIT_W'(1);
                    end else if (level != '0) begin
                        load_frame = 1'b1;
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Pop the head word and snapshot the link configuration for the whole frame
        if (load_frame) begin
            pop_c     = 1'b1;
            state_d   = START;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            shift_d   = head;
            div_d     = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
            par_en_d  = (cfg_parity != 2'b00);
            stop2_d   = cfg_stop2;
            case (cfg_parity)
                2'b01:   par_bit_d = ^head;
                2'b10:   par_bit_d = ~^head;
                default: par_bit_d = 1'b1;
            endcase
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase

        // Registered pulse lands on the last clock of the final stop bit
        frame_done_d = (state_d == STOP) && (div_cnt_d == div_d - DIV_W'(1)) &&
                       (bit_cnt_d == (stop2_d ? BIT_W'(1) : BIT_W'(0)));
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: pushed words go to a scoreboard queue and are
// checked clock by clock against the serial line as each frame is received.
module tb_uart_tx_fifo;
    logic        clk = 1'b0;
    logic        rstn;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        tx;
    logic        busy;
    logic [4:0]  level;
    logic        frame_done;

    int evals = 0;
    int fails = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_W(16)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .cfg_div(cfg_div), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .tx(tx), .busy(busy), .level(level), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        evals++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one word; it is accepted at the first edge that follows a negedge with s_ready high
    task automatic push(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("push_timeout", 32'(s_ready), 32'd1);
        else exp_q.push_back(d);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Wait for a start bit, then check every clock of the frame against the scoreboard head
    task automatic recv(input int div, input logic [1:0] par, input bit st2, output int gap);
        logic [7:0] d;
        logic       seq [$];
        int         fd;
        bit         first;
        gap = 0;
        @(negedge clk);
        while (tx !== 1'b0 && gap < 5000) begin
            gap++;
            @(negedge clk);
        end
        if (tx !== 1'b0) begin
            chk("start_timeout", 32'(tx), 32'd0);
            return;
        end
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        d = exp_q.pop_front();
        seq.push_back(1'b0);
        for (int i = 0; i < 8; i++) seq.push_back(d[i]);
        case (par)
            2'b01:   seq.push_back(^d);
            2'b10:   seq.push_back(~^d);
            2'b11:   seq.push_back(1'b1);
            default: ;
        endcase
        seq.push_back(1'b1);
        if (st2) seq.push_back(1'b1);
        fd    = 0;
        first = 1'b1;
        foreach (seq[b]) begin
            for (int c = 0; c < div; c++) begin
                if (!first) @(negedge clk);
                first = 1'b0;
                chk($sformatf("tx_bit%0d_clk%0d_word%02h", b, c, d), 32'(tx), 32'(seq[b]));
                if (frame_done === 1'b1) fd++;
            end
        end
        chk("frame_done_count", 32'(fd), 32'd1);
    endtask

    initial begin
        int g;
        int g2;
        rstn       = 1'b0;
        s_valid    = 1'b0;
        s_data     = 8'h00;
        cfg_div    = 16'd4;
        cfg_parity = 2'b01;
        cfg_stop2  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 0x55, div 4, even parity, one stop bit: 44 clocks
        push(8'h55);
        recv(4, 2'b01, 1'b0, g);
        chk("t1_latency", 32'(g), 32'd1);
        @(negedge clk);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_tx_idle", 32'(tx), 32'd1);

        // Odd parity, two stop bits: 48 clocks
        cfg_parity = 2'b10;
        cfg_stop2  = 1'b1;
        push(8'h55);
        recv(4, 2'b10, 1'b1, g);
        chk("t2_latency", 32'(g), 32'd1);
        @(negedge clk);
        chk("t2_busy_after", 32'(busy), 32'd0);

        // div 0 behaves as 1, no parity: 10-clock frame
        cfg_div    = 16'd0;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        push(8'hA3);
        recv(1, 2'b00, 1'b0, g);
        chk("t3_latency", 32'(g), 32'd1);
        @(negedge clk);

        // Mark parity sanity
        cfg_div    = 16'd2;
        cfg_parity = 2'b11;
        push(8'h0F);
        recv(2, 2'b11, 1'b0, g);
        @(negedge clk);

        // Fill to full while sending; frames must be contiguous
        cfg_div    = 16'd2;
        cfg_parity = 2'b00;
        fork
            begin
                for (int i = 0; i < 17; i++) push(8'(8'h90 + i * 7));
                @(negedge clk);
                chk("t4_full_level", 32'(level), 32'd16);
                chk("t4_full_ready", 32'(s_ready), 32'd0);
                push(8'h3C);
            end
            begin
                int gg;
                for (int i = 0; i < 18; i++) begin
                    recv(2, 2'b00, 1'b0, gg);
                    if (i > 0) chk($sformatf("t4_gap%0d", i), 32'(gg), 32'd0);
                end
            end
        join
        @(negedge clk);
        chk("t4_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("t4_level_after", 32'(level), 32'd0);
        chk("t4_busy_after", 32'(busy), 32'd0);

        // cfg_div change mid-frame only affects the following frame
        cfg_div = 16'd4;
        push(8'hC6);
        push(8'h39);
        fork
            begin
                recv(4, 2'b00, 1'b0, g);
                recv(8, 2'b00, 1'b0, g2);
                chk("t5_gap", 32'(g2), 32'd0);
            end
            begin
                repeat (12) @(negedge clk);
                cfg_div = 16'd8;
            end
        join
        @(negedge clk);
        chk("t5_busy_after", 32'(busy), 32'd0);

        // Reset during DATA with three words queued
        cfg_div    = 16'd4;
        cfg_parity = 2'b01;
        push(8'h81);
        push(8'h42);
        push(8'h24);
        push(8'h18);
        repeat (8) @(negedge clk);
        chk("t6_level_before", 32'(level), 32'd3);
        rstn = 1'b0;
        #1;
        chk("t6_rst_tx", 32'(tx), 32'd1);
        chk("t6_rst_level", 32'(level), 32'd0);
        chk("t6_rst_ready", 32'(s_ready), 32'd1);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_frame_done", 32'(frame_done), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i % 8 == 0) begin
                chk($sformatf("t6_idle_tx%0d", i), 32'(tx), 32'd1);
                chk($sformatf("t6_idle_busy%0d", i), 32'(busy), 32'd0);
                chk($sformatf("t6_idle_fd%0d", i), 32'(frame_done), 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end
endmodule
